// File: rtl/muldiv_seq.sv
// Multicycle radix-2 DIV / MLA unit with fetch/decode stall and result hold.
// Optional MULDIV_FASTPATH_EN: zero src_b completes from IDLE in one cycle.
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [WIDTH-1:0] src_c,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] dv_q, dv_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_t;
  logic [WIDTH:0]   it_acc;
  logic [WIDTH-1:0] it_sh;
  logic [WIDTH-1:0] it_dv;
  logic             last;
  logic             fast;
  logic             load;

`ifdef MULDIV_FASTPATH_EN
  assign fast = (src_b == '0);
`else
  assign fast = 1'b0;
`endif

  assign last = (cnt_q == CNT_W'(WIDTH - 1));

  // acc holds R (DIV) or P (MLA); sh holds Q or A; dv holds D or B
  always_comb begin
    div_sh = {acc_q[WIDTH-1:0], sh_q[WIDTH-1]};
    div_t  = div_sh - {1'b0, dv_q};
    it_acc = acc_q;
    it_sh  = sh_q;
    it_dv  = dv_q;
    if (op_q) begin
      if (dv_q[0]) begin
        it_acc = {1'b0, acc_q[WIDTH-1:0] + sh_q};
      end
      it_sh = sh_q << 1;
      it_dv = dv_q >> 1;
    end else if (!div_t[WIDTH]) begin
      it_acc = div_t;
      it_sh  = {sh_q[WIDTH-2:0], 1'b1};
    end else begin
      it_acc = div_sh;
      it_sh  = {sh_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    dv_d    = dv_q;
    res_d   = res_q;
    rem_d   = rem_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load = 1'b1;
          if (fast) begin
            state_d = DONE;
            res_d   = op ? src_c : '1;
            rem_d   = op ? '0 : src_a;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        acc_d = it_acc;
        sh_d  = it_sh;
        dv_d  = it_dv;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
          res_d   = op_q ? it_acc[WIDTH-1:0] : it_sh;
          rem_d   = op_q ? '0 : it_acc[WIDTH-1:0];
        end
      end
      DONE: begin
        state_d = IDLE;
        if (start) begin
          load    = 1'b1;
          state_d = BUSY;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      op_d  = op;
      cnt_d = '0;
      acc_d = op ? {1'b0, src_c} : '0;
      sh_d  = src_a;
      dv_d  = src_b;
    end
    // abort wins over everything, including a fresh start
    if (flush) begin
      state_d = IDLE;
      res_d   = res_q;
      rem_d   = rem_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      acc_q   <= '0;
      sh_q    <= '0;
      dv_q    <= '0;
      res_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      dv_q    <= dv_d;
      res_q   <= res_d;
      rem_q   <= rem_d;
    end
  end

  assign stall     = ((state_q == IDLE) && start)
                   || (state_q == BUSY);
  assign busy      = (state_q == BUSY);
  assign done      = (state_q == DONE);
  assign result    = res_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: arithmetic model, latency,
// back-to-back, flush and async reset scenarios.
module tb_muldiv_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic [W-1:0] src_c = '0;
  logic         stall, busy, done;
  logic [W-1:0] result, remainder;

  int tests_run = 0;
  int tests_failed = 0;
  logic [W-1:0] last_res = '0;
  logic [W-1:0] last_rem = '0;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .src_c(src_c),
    .flush(flush), .stall(stall), .busy(busy), .done(done),
    .result(result), .remainder(remainder)
  );

  function automatic void model(input logic o,
    input logic [W-1:0] a, input logic [W-1:0] b,
    input logic [W-1:0] c,
    output logic [W-1:0] r, output logic [W-1:0] m);
    if (o) begin
      r = a * b + c;
      m = '0;
    end else if (b == '0) begin
      r = '1;
      m = a;
    end else begin
      r = a / b;
      m = a % b;
    end
  endfunction

  function automatic int exp_lat(input logic [W-1:0] b);
`ifdef MULDIV_FASTPATH_EN
    if (b == '0) return 1;
`endif
    return W + 1;
  endfunction

  // Drives one op (cycle 0 = start high) and returns when done or
  // after a bounded number of cycles; leaves time inside the done cycle.
  task automatic run_op(input logic o, input logic [W-1:0] a,
    input logic [W-1:0] b, input logic [W-1:0] c,
    output int dcyc, output int bcnt, output int scnt);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b; src_c = c;
    dcyc = -1; bcnt = 0; scnt = 0;
    for (int cyc = 0; cyc < W + 6 && dcyc < 0; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        start = 1'b0;
      end
      #1;
      if (busy) bcnt++;
      if (stall) scnt++;
      if (done) dcyc = cyc;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: busy=%b done=%b stall=%b want 0",
               busy, done, stall);
    end
    tests_run++;
    if (result !== '0 || remainder !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: result=%h rem=%h want 0",
               result, remainder);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_div_basic();
    int d, b, s;
    run_op(1'b0, 32'd100, 32'd7, 32'd0, d, b, s);
    tests_run++;
    if (d !== W + 1 || b !== W || s !== W + 1) begin
      tests_failed++;
      $display("FAIL div_timing: done=%0d busy=%0d stall=%0d want %0d %0d %0d",
               d, b, s, W + 1, W, W + 1);
    end
    tests_run++;
    if (result !== 32'd14 || remainder !== 32'd2) begin
      tests_failed++;
      $display("FAIL div_100_7: got %0d r %0d want 14 r 2",
               result, remainder);
    end
    last_res = 32'd14; last_rem = 32'd2;
  endtask

  task automatic test_mla_wrap();
    int d, b, s;
    run_op(1'b1, 32'hFFFF_FFFF, 32'd3, 32'd5, d, b, s);
    tests_run++;
    if (d !== W + 1) begin
      tests_failed++;
      $display("FAIL mla_timing: done=%0d want %0d", d, W + 1);
    end
    tests_run++;
    if (result !== 32'h2 || remainder !== '0) begin
      tests_failed++;
      $display("FAIL mla_wrap: got %h r %h want 00000002 r 0",
               result, remainder);
    end
    last_res = 32'h2; last_rem = '0;
  endtask

  task automatic test_div_zero();
    int d, b, s;
    run_op(1'b0, 32'h1234, 32'd0, 32'd0, d, b, s);
    tests_run++;
    if (d !== exp_lat('0)) begin
      tests_failed++;
      $display("FAIL div0_timing: done=%0d want %0d", d, exp_lat('0));
    end
    tests_run++;
    if (b !== exp_lat('0) - 1 || s !== exp_lat('0)) begin
      tests_failed++;
      $display("FAIL div0_busy: busy=%0d stall=%0d want %0d %0d",
               b, s, exp_lat('0) - 1, exp_lat('0));
    end
    tests_run++;
    if (result !== 32'hFFFF_FFFF || remainder !== 32'h1234) begin
      tests_failed++;
      $display("FAIL div0_value: got %h r %h want ffffffff r 1234",
               result, remainder);
    end
    last_res = 32'hFFFF_FFFF; last_rem = 32'h1234;
  endtask

  task automatic test_hold();
    int bad = 0;
    int pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (done) pulses++;
      if (result !== last_res || remainder !== last_rem) bad++;
    end
    tests_run++;
    if (pulses !== 0 || bad !== 0) begin
      tests_failed++;
      $display("FAIL hold: extra_done=%0d changed=%0d want 0 0",
               pulses, bad);
    end
  endtask

  task automatic test_back_to_back();
    int d, b, s;
    int d2 = -1;
    run_op(1'b0, 32'd77, 32'd10, 32'd0, d, b, s);
    tests_run++;
    if (d !== W + 1 || result !== 32'd7 || remainder !== 32'd7) begin
      tests_failed++;
      $display("FAIL b2b_first: done=%0d got %0d r %0d want %0d 7 r 7",
               d, result, remainder, W + 1);
    end
    start = 1'b1; op = 1'b0; src_a = 32'd9; src_b = 32'd3;
    for (int n = 1; n < W + 6 && d2 < 0; n++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (done) d2 = n;
    end
    start = 1'b0;
    tests_run++;
    if (d2 !== W + 1) begin
      tests_failed++;
      $display("FAIL b2b_gap: second done after %0d want %0d", d2, W + 1);
    end
    tests_run++;
    if (result !== 32'd3 || remainder !== 32'd0) begin
      tests_failed++;
      $display("FAIL b2b_value: got %0d r %0d want 3 r 0",
               result, remainder);
    end
    last_res = 32'd3; last_rem = '0;
  endtask

  task automatic test_random();
    int d, b, s;
    int bad_val = 0;
    int bad_lat = 0;
    logic o;
    logic [W-1:0] a, bb, c, er, em;
    for (int i = 0; i < 24; i++) begin
      o  = 1'($urandom_range(0, 1));
      a  = $urandom;
      c  = $urandom;
      case ($urandom_range(0, 4))
        0: bb = '0;
        1: bb = W'($urandom_range(1, 15));
        2: bb = a;
        default: bb = $urandom;
      endcase
      model(o, a, bb, c, er, em);
      run_op(o, a, bb, c, d, b, s);
      if (result !== er || remainder !== em) begin
        bad_val++;
        $display("FAIL rand_value: op=%b a=%h b=%h c=%h got %h/%h want %h/%h",
                 o, a, bb, c, result, remainder, er, em);
      end
      if (d !== exp_lat(bb)) bad_lat++;
      last_res = er; last_rem = em;
    end
    tests_run++;
    if (bad_val !== 0) begin
      tests_failed++;
      $display("FAIL rand_values: %0d bad want 0", bad_val);
    end
    tests_run++;
    if (bad_lat !== 0) begin
      tests_failed++;
      $display("FAIL rand_latency: %0d bad want 0", bad_lat);
    end
  endtask

  task automatic test_flush();
    int pulses = 0;
    @(negedge clk);
    start = 1'b1; op = 1'b0; src_a = 32'd1000; src_b = 32'd3;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_pre: busy=%b want 1", busy);
    end
    flush = 1'b1; start = 1'b1;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_idle: busy=%b done=%b stall=%b want 0",
               busy, done, stall);
    end
    repeat (W + 4) begin
      @(negedge clk);
      #1;
      if (done) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin
      tests_failed++;
      $display("FAIL flush_nodone: pulses=%0d want 0", pulses);
    end
    tests_run++;
    if (result !== last_res || remainder !== last_rem) begin
      tests_failed++;
      $display("FAIL flush_hold: got %h/%h want %h/%h",
               result, remainder, last_res, last_rem);
    end
  endtask

  task automatic test_async_reset();
    int d, b, s;
    @(negedge clk);
    start = 1'b1; op = 1'b1;
    src_a = 32'h1357_9BDF; src_b = 32'h0F0F_1234; src_c = 32'd11;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL areset_pre: busy=%b want 1", busy);
    end
    #1;
    reset = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0
        || result !== '0 || remainder !== '0) begin
      tests_failed++;
      $display("FAIL areset_now: busy=%b done=%b res=%h rem=%h want 0",
               busy, done, result, remainder);
    end
    @(negedge clk);
    reset = 1'b1;
    run_op(1'b0, 32'd50, 32'd5, 32'd0, d, b, s);
    tests_run++;
    if (d !== W + 1 || result !== 32'd10 || remainder !== 32'd0) begin
      tests_failed++;
      $display("FAIL areset_after: done=%0d got %0d r %0d want %0d 10 r 0",
               d, result, remainder, W + 1);
    end
  endtask

  initial begin
    test_reset();
    test_div_basic();
    test_hold();
    test_mla_wrap();
    test_div_zero();
    test_back_to_back();
    test_random();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
